// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns datapath load/store requests into a
// single-outstanding bus transaction, stalling the pipeline until the bus replies.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;
  logic        access, aligned;

  assign access  = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    timeout_d  = timeout_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
    bus_req    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            state_d = BUSY;
            addr_d  = addr;
            wdata_d = wdata;
            we_d    = memwrite;
            cnt_d   = 8'd0;
            stall   = 1'b1;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      BUSY: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        // An ack arriving on the last allowed cycle still completes normally.
        if (bus_ack) begin
          if (!we_q) rdata_d = bus_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!we_q) rdata_d = ERRDATA;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      rdata_q    <= 32'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign rdata     = rdata_q;
  assign misalign  = misalign_q;
  assign timeout   = timeout_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, max BUSY cycles waited for bus_ack before abort (1..255).
REQ-002 Parameter ERRDATA, default 32'hDEADBEEF, rdata value returned on timeout.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 memread  in  1  datapath load request for current instruction.
REQ-006 memwrite  in  1  datapath store request for current instruction.
REQ-007 addr  in  32  byte address (datapath ALU result).
REQ-008 wdata  in  32  store data (datapath rt read port).
REQ-009 rdata  out  32  load data to datapath result mux.
REQ-010 stall  out  1  high = datapath SHALL hold PC and suppress regwrite.
REQ-011 misalign  out  1  one-cycle pulse, rejected unaligned access.
REQ-012 timeout  out  1  sticky flag, a bus access was aborted.
REQ-013 bus_req  out  1  memory request valid.
REQ-014 bus_we  out  1  1 = write, 0 = read.
REQ-015 bus_addr  out  32  word-aligned address.
REQ-016 bus_wdata  out  32  write data.
REQ-017 bus_rdata  in  32  read data, valid when bus_ack high.
REQ-018 bus_ack  in  1  one-cycle completion strobe from memory.

Function
REQ-019 FSM SHALL have states IDLE, BUSY, DONE.
REQ-020 IDLE: access = memread|memwrite; if access and addr[1:0]==0, SHALL latch addr, wdata, we=memwrite (memwrite wins if both) and go BUSY.
REQ-021 IDLE with access and addr[1:0]!=0: no bus request, stall low, misalign high for exactly the next cycle, rdata unchanged, state stays IDLE.
REQ-022 stall = (IDLE & access & aligned) | BUSY, combinational; low in DONE and for misaligned access.
REQ-023 BUSY: bus_req=1; bus_we/bus_addr/bus_wdata SHALL be driven from latched registers and stay stable until exit.
REQ-024 BUSY with bus_ack: if read, rdata <= bus_rdata; go DONE; minimum access latency = 2 cycles of stall (IDLE accept + BUSY ack).
REQ-025 BUSY wait counter SHALL reset to 0 on entry and increment each BUSY cycle without ack; at count == TIMEOUT-1 without ack go DONE, set timeout=1, read returns rdata <= ERRDATA, write discarded.
REQ-026 bus_ack and timeout limit in same cycle: ack wins, timeout not set.
REQ-027 DONE: bus_req=0, stall=0, rdata valid; SHALL go IDLE next cycle unconditionally and SHALL NOT accept a new access in DONE.
REQ-028 bus_ack outside BUSY SHALL be ignored (no state, rdata or flag change).
REQ-029 rdata SHALL hold its last value except on REQ-024/REQ-025 updates; writes never modify rdata.
REQ-030 timeout SHALL remain set until reset.

Reset
REQ-031 On reset: state IDLE, counter 0, rdata 0, misalign 0, timeout 0, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0; stall follows REQ-022 from IDLE.
REQ-032 reset asserted in BUSY SHALL abort the access: bus_req low after that edge, no rdata update; a late bus_ack SHALL be ignored.

Verification
REQ-033 Read: memread=1, addr=0x40, ack 3 cycles later with bus_rdata=0x12345678 -> stall high 4 cycles, bus_addr=0x40, bus_we=0, rdata=0x12345678 in DONE, stall low.
REQ-034 Write: memwrite=1, addr=0x100, wdata=0xCAFEF00D, immediate ack -> bus_we=1, bus_wdata=0xCAFEF00D, stall high 2 cycles, rdata unchanged.
REQ-035 Misaligned: memread=1, addr=0x42 -> bus_req never high, stall 0, misalign=1 one cycle.
REQ-036 Timeout: memread=1, addr=0x80, no ack, TIMEOUT=15 -> after 15 BUSY cycles DONE, rdata=0xDEADBEEF, timeout=1 held; ack on exactly cycle 15 -> real data, timeout=0.
REQ-037 Reset mid-BUSY: reset in BUSY cycle 2, then ack -> IDLE, bus_req 0, rdata 0, all flags 0.
REQ-038 Back-to-back: memread held across DONE -> no second access started in DONE; new access accepted next IDLE cycle.
